// File: rtl/prog_sequencer.sv
// prog_sequencer: fetch and sequencing unit for the 9-bit accumulator core.
// It owns the program counter, the decoder mode register and the
// previous-instruction register. It applies branch and Ack results from the
// decoder and runs a Start/Done handshake with the host.
//
// Ports:
//   Clk             system clock, rising edge
//   Reset           synchronous, active-high
//   Start           level request to begin a run
//   Hold            freeze all registers while in RUN
//   Instruction     current ROM word at ProgCtr
//   NextState       decoder mode for next cycle (00 Reg, 01 Tgt, 10 Imm, 11 illegal)
//   BranchEn        load ProgCtr from BranchTarget
//   BranchTarget    absolute branch destination
//   AckIn           decoder saw the done instruction
//   ProgCtr         instruction ROM address
//   CurrState       mode fed back to the decoder
//   PrevInstruction instruction latched on the previous advance
//   Run             high only in RUN, qualifies datapath write enables
//   Done            high in DONE
//   PcWrap          sticky: PC incremented past its maximum
//   IllegalMode     sticky: NextState==11 seen while advancing
//   CycleCount      saturating count of advancing RUN cycles
//
// state  | meaning
// S_IDLE | waiting for Start
// S_RUN  | advancing one instruction per cycle unless Hold
// S_DONE | program finished, waiting for Start to drop
module prog_sequencer #(
  parameter int unsigned PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Hold,
  input  logic [8:0]       Instruction,
  input  logic [1:0]       NextState,
  input  logic             BranchEn,
  input  logic [8:0]       BranchTarget,
  input  logic             AckIn,
  output logic [PC_W-1:0]  ProgCtr,
  output logic [1:0]       CurrState,
  output logic [8:0]       PrevInstruction,
  output logic             Run,
  output logic             Done,
  output logic             PcWrap,
  output logic             IllegalMode,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [1:0]        mode_q;
  logic [8:0]        prev_q;
  logic              run_q;
  logic              done_q;
  logic              wrap_q;
  logic              ill_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [PC_W-1:0]   pc_d;
  logic              wrap_d;
  logic              ill_d;
  logic [1:0]        mode_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              ack_d;

  always_comb begin
    // Branch targets are absolute; they are zero-extended or truncated to PC_W.
    pc_d   = BranchEn ? PC_W'(BranchTarget) : pc_q + PC_W'(1);
    // Only a sequential increment off the top counts as a wrap.
    wrap_d = !BranchEn && (pc_q == {PC_W{1'b1}});
    ill_d  = (NextState == 2'b11);
    mode_d = ill_d ? 2'b00 : NextState;
    cnt_d  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    // In Target/Immediate mode the word is an operand, so Ack is not honoured.
    ack_d  = AckIn && (mode_q == 2'b00);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_W'(START_ADDR);
      mode_q  <= 2'b00;
      prev_q  <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
            pc_q    <= PC_W'(START_ADDR);
            mode_q  <= 2'b00;
            prev_q  <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            ill_q   <= 1'b0;
          end
        end
        S_RUN: begin
          if (!Hold) begin
            cnt_q  <= cnt_d;
            prev_q <= Instruction;
            mode_q <= mode_d;
            if (ill_d) ill_q <= 1'b1;
            if (ack_d) begin
              // Ack beats a simultaneous branch; ProgCtr freezes here.
              state_q <= S_DONE;
              run_q   <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc_q <= pc_d;
              if (wrap_d) wrap_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Start must drop before another run can begin.
          if (!Start) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          run_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ProgCtr         = pc_q;
  assign CurrState       = mode_q;
  assign PrevInstruction = prev_q;
  assign Run             = run_q;
  assign Done            = done_q;
  assign PcWrap          = wrap_q;
  assign IllegalMode     = ill_q;
  assign CycleCount      = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Hold;
  logic [8:0] Instruction;
  logic [1:0] NextState;
  logic       BranchEn;
  logic [8:0] BranchTarget;
  logic       AckIn;

  logic [9:0]  pc;
  logic [1:0]  cs;
  logic [8:0]  prev;
  logic        run, done, wrap, ill;
  logic [15:0] cnt;

  logic [3:0]  s_pc;
  logic [1:0]  s_cs;
  logic [8:0]  s_prev;
  logic        s_run, s_done, s_wrap, s_ill;
  logic [3:0]  s_cnt;

  int vectors = 0;
  int miscompares = 0;

  prog_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Hold(Hold),
    .Instruction(Instruction), .NextState(NextState), .BranchEn(BranchEn),
    .BranchTarget(BranchTarget), .AckIn(AckIn),
    .ProgCtr(pc), .CurrState(cs), .PrevInstruction(prev), .Run(run),
    .Done(done), .PcWrap(wrap), .IllegalMode(ill), .CycleCount(cnt)
  );

  prog_sequencer #(.PC_W(4), .START_ADDR(0), .CNT_W(4)) dut_s (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Hold(Hold),
    .Instruction(Instruction), .NextState(NextState), .BranchEn(BranchEn),
    .BranchTarget(BranchTarget), .AckIn(AckIn),
    .ProgCtr(s_pc), .CurrState(s_cs), .PrevInstruction(s_prev), .Run(s_run),
    .Done(s_done), .PcWrap(s_wrap), .IllegalMode(s_ill), .CycleCount(s_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    vectors++; if (pc !== 10'd0)   begin miscompares++; $display("FAIL rst_pc got %0h exp 0", pc); end
    vectors++; if (cs !== 2'b00)   begin miscompares++; $display("FAIL rst_cs got %0b exp 00", cs); end
    vectors++; if (prev !== 9'd0)  begin miscompares++; $display("FAIL rst_prev got %0h exp 0", prev); end
    vectors++; if (run !== 1'b0)   begin miscompares++; $display("FAIL rst_run got %0b exp 0", run); end
    vectors++; if (done !== 1'b0)  begin miscompares++; $display("FAIL rst_done got %0b exp 0", done); end
    vectors++; if (wrap !== 1'b0 || ill !== 1'b0) begin miscompares++; $display("FAIL rst_flags got %0b%0b exp 00", wrap, ill); end
    vectors++; if (cnt !== 16'd0)  begin miscompares++; $display("FAIL rst_cnt got %0d exp 0", cnt); end
    Reset = 1'b0;
  endtask

  task automatic test_linear();
    Start = 1'b1;
    tick();
    vectors++; if (run !== 1'b1 || pc !== 10'd0) begin miscompares++; $display("FAIL lin_start got run=%0b pc=%0h exp run=1 pc=0", run, pc); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (pc !== 10'(i)) begin miscompares++; $display("FAIL lin_pc got %0h exp %0h", pc, i); end
      Instruction = (i == 3) ? 9'h00F : 9'h000;
      AckIn = (i == 3);
      tick();
    end
    AckIn = 1'b0;
    vectors++; if (done !== 1'b1 || run !== 1'b0) begin miscompares++; $display("FAIL lin_done got done=%0b run=%0b exp 1 0", done, run); end
    vectors++; if (pc !== 10'd3) begin miscompares++; $display("FAIL lin_pc_hold got %0h exp 3", pc); end
    vectors++; if (cnt !== 16'd4) begin miscompares++; $display("FAIL lin_cnt got %0d exp 4", cnt); end
    tick();
    vectors++; if (done !== 1'b1 || run !== 1'b0) begin miscompares++; $display("FAIL lin_done_held got done=%0b run=%0b exp 1 0", done, run); end
    Start = 1'b0;
    tick();
    vectors++; if (done !== 1'b0 || run !== 1'b0) begin miscompares++; $display("FAIL lin_idle got done=%0b run=%0b exp 0 0", done, run); end
  endtask

  task automatic test_branch();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Instruction = 9'h000;
      tick();
    end
    vectors++; if (pc !== 10'd4) begin miscompares++; $display("FAIL br_pc4 got %0h exp 4", pc); end
    NextState = 2'b01; Instruction = 9'h055;
    tick();
    vectors++; if (cs !== 2'b01 || pc !== 10'd5 || prev !== 9'h055) begin miscompares++; $display("FAIL br_tgt got cs=%0b pc=%0h prev=%0h exp 01 5 55", cs, pc, prev); end
    NextState = 2'b00; Instruction = 9'h0AB; BranchEn = 1'b1; BranchTarget = 9'h1A0;
    tick();
    vectors++; if (pc !== 10'h1A0 || cs !== 2'b00 || prev !== 9'h0AB) begin miscompares++; $display("FAIL br_jump got pc=%0h cs=%0b prev=%0h exp 1a0 00 ab", pc, cs, prev); end
    BranchEn = 1'b0; NextState = 2'b10; Instruction = 9'h123;
    tick();
    vectors++; if (cs !== 2'b10 || pc !== 10'h1A1) begin miscompares++; $display("FAIL br_imm got cs=%0b pc=%0h exp 10 1a1", cs, pc); end
    NextState = 2'b00; Instruction = 9'h00F; AckIn = 1'b1;
    tick();
    vectors++; if (done !== 1'b0 || run !== 1'b1 || pc !== 10'h1A2) begin miscompares++; $display("FAIL br_operand got done=%0b run=%0b pc=%0h exp 0 1 1a2", done, run, pc); end
    BranchEn = 1'b1;
    tick();
    vectors++; if (done !== 1'b1 || pc !== 10'h1A2) begin miscompares++; $display("FAIL br_ack_wins got done=%0b pc=%0h exp 1 1a2", done, pc); end
    vectors++; if (cnt !== 16'd9) begin miscompares++; $display("FAIL br_cnt got %0d exp 9", cnt); end
    AckIn = 1'b0; BranchEn = 1'b0; Instruction = 9'h000;
    tick();
  endtask

  task automatic test_hold();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Instruction = 9'h011; tick();
    Instruction = 9'h022; tick();
    vectors++; if (pc !== 10'd2 || prev !== 9'h022 || cnt !== 16'd2) begin miscompares++; $display("FAIL hold_pre got pc=%0h prev=%0h cnt=%0d exp 2 22 2", pc, prev, cnt); end
    Hold = 1'b1; Instruction = 9'h1FF; NextState = 2'b01; BranchEn = 1'b1; AckIn = 1'b1;
    repeat (3) tick();
    vectors++; if (pc !== 10'd2 || cnt !== 16'd2 || prev !== 9'h022) begin miscompares++; $display("FAIL hold_frozen got pc=%0h cnt=%0d prev=%0h exp 2 2 22", pc, cnt, prev); end
    vectors++; if (cs !== 2'b00 || run !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL hold_state got cs=%0b run=%0b done=%0b exp 00 1 0", cs, run, done); end
    Hold = 1'b0; NextState = 2'b00; BranchEn = 1'b0; AckIn = 1'b0; Instruction = 9'h000;
    repeat (20) tick();
    vectors++; if (s_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_cnt got %0d exp 15", s_cnt); end
    vectors++; if (cnt !== 16'd22 || pc !== 10'd22) begin miscompares++; $display("FAIL sat_wide got cnt=%0d pc=%0d exp 22 22", cnt, pc); end
    vectors++; if (s_pc !== 4'd6 || s_wrap !== 1'b1 || wrap !== 1'b0) begin miscompares++; $display("FAIL sat_wrap got s_pc=%0d s_wrap=%0b wrap=%0b exp 6 1 0", s_pc, s_wrap, wrap); end
  endtask

  task automatic test_reset_mid_run();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    vectors++; if (pc !== 10'd0 || cs !== 2'b00 || cnt !== 16'd0) begin miscompares++; $display("FAIL mrst_regs got pc=%0h cs=%0b cnt=%0d exp 0 00 0", pc, cs, cnt); end
    vectors++; if (run !== 1'b0 || done !== 1'b0 || s_wrap !== 1'b0 || s_cnt !== 4'd0) begin miscompares++; $display("FAIL mrst_ctl got run=%0b done=%0b s_wrap=%0b s_cnt=%0d exp 0 0 0 0", run, done, s_wrap, s_cnt); end
    tick();
    vectors++; if (run !== 1'b0) begin miscompares++; $display("FAIL mrst_idle got run=%0b exp 0", run); end
  endtask

  task automatic test_wrap_illegal();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (15) tick();
    vectors++; if (s_pc !== 4'd15 || s_wrap !== 1'b0) begin miscompares++; $display("FAIL wrap_pre got pc=%0d wrap=%0b exp 15 0", s_pc, s_wrap); end
    tick();
    vectors++; if (s_pc !== 4'd0 || s_wrap !== 1'b1) begin miscompares++; $display("FAIL wrap_post got pc=%0d wrap=%0b exp 0 1", s_pc, s_wrap); end
    NextState = 2'b11;
    tick();
    vectors++; if (s_cs !== 2'b00 || s_ill !== 1'b1 || cs !== 2'b00 || ill !== 1'b1) begin miscompares++; $display("FAIL ill_set got s_cs=%0b s_ill=%0b cs=%0b ill=%0b exp 00 1 00 1", s_cs, s_ill, cs, ill); end
    NextState = 2'b00;
    tick();
    vectors++; if (s_ill !== 1'b1) begin miscompares++; $display("FAIL ill_sticky got %0b exp 1", s_ill); end
    Start = 1'b1; AckIn = 1'b1;
    tick();
    AckIn = 1'b0;
    vectors++; if (s_done !== 1'b1) begin miscompares++; $display("FAIL rs_done got %0b exp 1", s_done); end
    repeat (3) tick();
    vectors++; if (s_done !== 1'b1 || s_run !== 1'b0) begin miscompares++; $display("FAIL rs_no_restart got done=%0b run=%0b exp 1 0", s_done, s_run); end
    Start = 1'b0;
    tick();
    vectors++; if (s_done !== 1'b0 || s_run !== 1'b0) begin miscompares++; $display("FAIL rs_idle got done=%0b run=%0b exp 0 0", s_done, s_run); end
    Start = 1'b1;
    tick();
    vectors++; if (s_run !== 1'b1 || s_pc !== 4'd0 || s_wrap !== 1'b0 || s_ill !== 1'b0 || s_cnt !== 4'd0) begin miscompares++; $display("FAIL rs_restart got run=%0b pc=%0d wrap=%0b ill=%0b cnt=%0d exp 1 0 0 0 0", s_run, s_pc, s_wrap, s_ill, s_cnt); end
    Start = 1'b0;
    repeat (15) tick();
    BranchEn = 1'b1; BranchTarget = 9'h003;
    tick();
    BranchEn = 1'b0;
    vectors++; if (s_pc !== 4'd3 || s_wrap !== 1'b0) begin miscompares++; $display("FAIL br_nowrap got pc=%0d wrap=%0b exp 3 0", s_pc, s_wrap); end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Hold = 1'b0; Instruction = 9'h000;
    NextState = 2'b00; BranchEn = 1'b0; BranchTarget = 9'h000; AckIn = 1'b0;
    test_reset();
    test_linear();
    test_branch();
    test_hold();
    test_reset_mid_run();
    test_wrap_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Fetch and sequencing unit that drives the 9-bit accumulator core's instruction decoder. It owns the program counter, the decoder mode register (Regular/Target/Immediate) and the previous-instruction register. It applies branch and Ack results from the decoder, and runs a Start/Done handshake with the testbench or host. It sits between the instruction ROM and the decoder; its Run output qualifies every datapath write enable.

Parameters:
PC_W, 10, program counter width; instruction ROM depth is 2^PC_W
START_ADDR, 0, PC value loaded when a run starts
CNT_W, 16, width of the saturating cycle counter

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  level request to begin a program run
Hold  input  1  freeze: while high in RUN, all registers keep their values
Instruction  input  9  current word from instruction ROM at ProgCtr
NextState  input  2  decoder mode for next cycle (00 Regular, 01 Target, 10 Immediate, 11 illegal)
BranchEn  input  1  decoder: load PC from BranchTarget
BranchTarget  input  9  absolute branch destination
AckIn  input  1  decoder: done instruction decoded
ProgCtr  output  PC_W  instruction ROM address
CurrState  output  2  mode fed back to decoder
PrevInstruction  output  9  instruction latched on previous advance
Run  output  1  high only in RUN; gates datapath write enables
Done  output  1  high in DONE
PcWrap  output  1  sticky: PC incremented past 2^PC_W-1
IllegalMode  output  1  sticky: NextState==11 seen while advancing
CycleCount  output  CNT_W  cycles spent in RUN, saturating

Behaviour:
- FSM states IDLE, RUN, DONE. Reset (any state, mid-run included) -> IDLE.
- Reset values: ProgCtr=START_ADDR, CurrState=00, PrevInstruction=0, Run=0, Done=0, PcWrap=0, IllegalMode=0, CycleCount=0.
- IDLE: on Start=1 go to RUN. Same edge: ProgCtr=START_ADDR, CurrState=00, PrevInstruction=0, CycleCount=0, both sticky flags cleared. Run rises the cycle after Start is sampled.
- RUN, Hold=0: one advance per cycle:
  - PrevInstruction <= Instruction.
  - CurrState <= NextState; if NextState==11, load 00 and set IllegalMode.
  - ProgCtr <= BranchEn ? zero-extended BranchTarget : ProgCtr+1 (mod 2^PC_W).
  - If the increment wraps from 2^PC_W-1 to 0, set PcWrap. A branch never sets PcWrap.
  - CycleCount increments and saturates at 2^CNT_W-1.
- RUN, Hold=1: no register changes and CycleCount does not increment. Run stays 1; the decoder must gate its own effects.
- AckIn is honoured only when CurrState==00, Hold=0 and RUN. In Target/Immediate mode the word is an operand and AckIn is ignored.
- On an honoured AckIn: go to DONE. ProgCtr and CycleCount freeze at their values in the Ack cycle (that cycle is counted). BranchEn is ignored that cycle.
- Simultaneous AckIn and BranchEn in Regular mode: Ack wins.
- DONE: Done=1, Run=0, all registers hold. Start=0 -> IDLE. Start held high stays in DONE, so a run requires Start to fall then rise again.
- ProgCtr is registered: ROM address changes only on an advancing edge, and Instruction is valid one ROM access later (combinational ROM read, same cycle).

Test Plan:
- Reset mid-run: run 5 cycles, assert Reset for 1 cycle -> next cycle ProgCtr=0, CurrState=00, Run=0, Done=0, CycleCount=0, state IDLE.
- Linear run: Start with ROM words NOP,NOP,NOP, then Done word 0_0000_1111 at PC 3 -> ProgCtr 0,1,2,3; Done=1 the cycle after PC 3; CycleCount=4; ProgCtr holds 3.
- Two-word branch: NextState=01 at PC 4, then at PC 5 BranchEn=1 with BranchTarget=9'h1A0 -> ProgCtr=0x1A0, CurrState back to 00, PrevInstruction = word at PC 5.
- Operand not Ack: CurrState=10 with Instruction=0_0000_1111 and AckIn=1 -> no DONE, ProgCtr increments.
- Hold and saturation: Hold=1 for 3 cycles -> ProgCtr, CycleCount, PrevInstruction unchanged. With CNT_W=4, run 20 cycles -> CycleCount=15.
- Wrap/illegal: PC_W=4 with no branch -> ProgCtr 15 -> 0 and PcWrap=1. Drive NextState=11 -> CurrState=00, IllegalMode=1. Start held through DONE -> no restart until Start toggles low then high.
